// File: rtl/tile_harness_mux_pkg.sv
// Shared types and helpers for the multi-slot tile harness.
package tile_harness_mux_pkg;

  // Slot-switch sequencer states.
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  // Narrowest select width that can address every slot (never below 1 bit).
  function automatic int min_sel_width(input int num_tiles);
    return (num_tiles > 1) ? $clog2(num_tiles) : 1;
  endfunction

endpackage

// File: rtl/tile_harness_mux_if.sv
// Harness-side CSR/data/GPIO and slot-select handshake bundle.
interface tile_harness_mux_if #(
  parameter int SEL_W         = 2,
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int GPIOS_NUM     = 35
);
  logic                     harness_en;
  logic                     tile_en;
  logic                     sel_req;
  logic [SEL_W-1:0]         tile_sel;
  logic                     sel_ack;
  logic                     sel_err;
  logic                     busy;
  logic [SEL_W-1:0]         active_tile;
  logic [CSR_IN_WIDTH-1:0]  csr_in;
  logic                     csr_in_re;
  logic [REG_WIDTH-1:0]     data_reg_a;
  logic [REG_WIDTH-1:0]     data_reg_b;
  logic [CSR_OUT_WIDTH-1:0] csr_out;
  logic                     csr_out_we;
  logic [REG_WIDTH-1:0]     data_reg_c;
  logic [GPIOS_NUM-1:0]     gpios_in;
  logic [GPIOS_NUM-1:0]     gpios_out;

  // Harness register file side.
  modport master (
    output harness_en, tile_en, sel_req, tile_sel, csr_in, data_reg_a, data_reg_b, gpios_in,
    input  sel_ack, sel_err, busy, active_tile, csr_in_re, csr_out, csr_out_we, data_reg_c,
           gpios_out
  );

  // Tile multiplexer side.
  modport slave (
    input  harness_en, tile_en, sel_req, tile_sel, csr_in, data_reg_a, data_reg_b, gpios_in,
    output sel_ack, sel_err, busy, active_tile, csr_in_re, csr_out, csr_out_we, data_reg_c,
           gpios_out
  );
endinterface

// File: rtl/tile_harness_mux_port_mask.sv
// Gates one slot's input bundle: the slot sees live harness values only when enabled.
module tile_port_mask #(
  parameter int CSR_W  = 16,
  parameter int REG_W  = 32,
  parameter int GPIO_W = 8
) (
  input  logic              en,
  input  logic [CSR_W-1:0]  csr_in,
  input  logic [REG_W-1:0]  data_a,
  input  logic [REG_W-1:0]  data_b,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [CSR_W-1:0]  csr_in_m,
  output logic [REG_W-1:0]  data_a_m,
  output logic [REG_W-1:0]  data_b_m,
  output logic [GPIO_W-1:0] gpio_in_m
);
  // Disabled slots are held at all-zero inputs.
  always_comb begin
    csr_in_m  = en ? csr_in  : '0;
    data_a_m  = en ? data_a  : '0;
    data_b_m  = en ? data_b  : '0;
    gpio_in_m = en ? gpio_in : '0;
  end
endmodule

// File: rtl/tile_harness_mux.sv
// Hosts NUM_TILES tiles behind one harness interface; one slot is active at a time and
// switching goes drain -> reset pulse on the new slot -> acknowledge.
module tile_harness_mux
  import tile_harness_mux_pkg::*;
#(
  parameter int NUM_TILES     = 4,
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int GPIOS_NUM     = 35,
  parameter int GPIO_OUT_W    = 16,
  parameter int GPIO_IN_LSB   = 16,
  parameter int GPIO_IN_W     = 8,
  parameter int DRAIN_CYCLES  = 4,
  parameter int SEL_W         = min_sel_width(NUM_TILES)
) (
  input  logic                               clk,
  input  logic                               arst_n,
  tile_harness_mux_if.slave                  hif,
  output logic [NUM_TILES-1:0]               t_rst_n,
  output logic [NUM_TILES*CSR_IN_WIDTH-1:0]  t_csr_in,
  output logic [NUM_TILES*REG_WIDTH-1:0]     t_data_reg_a,
  output logic [NUM_TILES*REG_WIDTH-1:0]     t_data_reg_b,
  output logic [NUM_TILES*GPIO_IN_W-1:0]     t_gpio_in,
  input  logic [NUM_TILES-1:0]               t_csr_in_re,
  input  logic [NUM_TILES*CSR_OUT_WIDTH-1:0] t_csr_out,
  input  logic [NUM_TILES-1:0]               t_csr_out_we,
  input  logic [NUM_TILES*REG_WIDTH-1:0]     t_data_reg_c,
  input  logic [NUM_TILES*GPIO_OUT_W-1:0]    t_gpio_out
);

  if (NUM_TILES < 2) begin : g_bad_num_tiles
    $error("tile_harness_mux: NUM_TILES must be at least 2");
  end
  if (GPIO_IN_LSB < GPIO_OUT_W) begin : g_bad_gpio_lsb
    $error("tile_harness_mux: GPIO_IN_LSB overlaps the tile output GPIOs");
  end
  if (GPIO_IN_LSB + GPIO_IN_W > GPIOS_NUM) begin : g_bad_gpio_in
    $error("tile_harness_mux: tile input GPIOs exceed GPIOS_NUM");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("tile_harness_mux: DRAIN_CYCLES must be at least 1");
  end
  if (SEL_W < min_sel_width(NUM_TILES)) begin : g_bad_sel_w
    $error("tile_harness_mux: SEL_W too narrow for NUM_TILES");
  end

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  state_e                   state_q, state_d;
  logic [SEL_W-1:0]         active_q, active_d;
  logic [SEL_W-1:0]         target_q, target_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [NUM_TILES-1:0]     t_rst_n_q, t_rst_n_d;
  logic [CSR_OUT_WIDTH-1:0] csr_out_q, csr_out_d;
  logic                     csr_out_we_q, csr_out_we_d;
  logic                     csr_in_re_q, csr_in_re_d;
  logic [REG_WIDTH-1:0]     data_c_q, data_c_d;
  logic [GPIO_OUT_W-1:0]    gpio_out_q, gpio_out_d;

  logic                     in_open;
  logic [GPIO_IN_W-1:0]     gpio_slice;
  logic                     sel_csr_in_re;
  logic [CSR_OUT_WIDTH-1:0] sel_csr_out;
  logic                     sel_csr_out_we;
  logic [REG_WIDTH-1:0]     sel_data_c;
  logic [GPIO_OUT_W-1:0]    sel_gpio_out;
  logic                     mux_zero;

  assign in_open    = (state_q == ST_ACTIVE) && hif.harness_en && hif.tile_en;
  assign gpio_slice = GPIO_IN_W'(hif.gpios_in >> GPIO_IN_LSB);

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_slot
    tile_port_mask #(
      .CSR_W  (CSR_IN_WIDTH),
      .REG_W  (REG_WIDTH),
      .GPIO_W (GPIO_IN_W)
    ) u_mask (
      .en        (in_open && (active_q == SEL_W'(i))),
      .csr_in    (hif.csr_in),
      .data_a    (hif.data_reg_a),
      .data_b    (hif.data_reg_b),
      .gpio_in   (gpio_slice),
      .csr_in_m  (t_csr_in[i*CSR_IN_WIDTH +: CSR_IN_WIDTH]),
      .data_a_m  (t_data_reg_a[i*REG_WIDTH +: REG_WIDTH]),
      .data_b_m  (t_data_reg_b[i*REG_WIDTH +: REG_WIDTH]),
      .gpio_in_m (t_gpio_in[i*GPIO_IN_W +: GPIO_IN_W])
    );
  end

  // Switch sequencer: accept/reject requests, drain, then reset-pulse the new slot.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (hif.sel_req) begin
          if (int'(hif.tile_sel) >= NUM_TILES) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (hif.tile_sel == active_q) begin
            ack_d = 1'b1;
          end else begin
            state_d  = ST_DRAIN;
            target_d = hif.tile_sel;
            cnt_d    = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_SWITCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SWITCH: begin
        state_d  = ST_ACTIVE;
        active_d = target_q;
        ack_d    = 1'b1;
      end
      default: state_d = ST_ACTIVE;
    endcase
    for (int i = 0; i < NUM_TILES; i++) begin
      t_rst_n_d[i] = !((state_d == ST_SWITCH) && (target_d == SEL_W'(i)));
    end
  end

  // Pick the outputs of the slot that will be active once this edge has passed.
  always_comb begin
    sel_csr_in_re  = 1'b0;
    sel_csr_out    = '0;
    sel_csr_out_we = 1'b0;
    sel_data_c     = '0;
    sel_gpio_out   = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (active_d == SEL_W'(i)) begin
        sel_csr_in_re  = t_csr_in_re[i];
        sel_csr_out    = t_csr_out[i*CSR_OUT_WIDTH +: CSR_OUT_WIDTH];
        sel_csr_out_we = t_csr_out_we[i];
        sel_data_c     = t_data_reg_c[i*REG_WIDTH +: REG_WIDTH];
        sel_gpio_out   = t_gpio_out[i*GPIO_OUT_W +: GPIO_OUT_W];
      end
    end
  end

  // Output register inputs: zeroed while switching, csr_out only captured on a write strobe.
  always_comb begin
    mux_zero     = (state_d == ST_SWITCH);
    csr_in_re_d  = mux_zero ? 1'b0 : sel_csr_in_re;
    csr_out_we_d = mux_zero ? 1'b0 : sel_csr_out_we;
    data_c_d     = mux_zero ? '0   : sel_data_c;
    gpio_out_d   = mux_zero ? '0   : sel_gpio_out;
    csr_out_d    = (!mux_zero && sel_csr_out_we) ? sel_csr_out : csr_out_q;
  end

  // All state and registered outputs; reset returns to slot 0 with every tile held in reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_ACTIVE;
      active_q     <= '0;
      target_q     <= '0;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      t_rst_n_q    <= '0;
      csr_out_q    <= '0;
      csr_out_we_q <= 1'b0;
      csr_in_re_q  <= 1'b0;
      data_c_q     <= '0;
      gpio_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      t_rst_n_q    <= t_rst_n_d;
      csr_out_q    <= csr_out_d;
      csr_out_we_q <= csr_out_we_d;
      csr_in_re_q  <= csr_in_re_d;
      data_c_q     <= data_c_d;
      gpio_out_q   <= gpio_out_d;
    end
  end

  assign t_rst_n         = t_rst_n_q;
  assign hif.sel_ack     = ack_q;
  assign hif.sel_err     = err_q;
  assign hif.busy        = (state_q != ST_ACTIVE);
  assign hif.active_tile = active_q;
  assign hif.csr_in_re   = csr_in_re_q;
  assign hif.csr_out     = csr_out_q;
  assign hif.csr_out_we  = csr_out_we_q;
  assign hif.data_reg_c  = data_c_q;
  assign hif.gpios_out   = {{(GPIOS_NUM - GPIO_OUT_W){1'b0}}, gpio_out_q};

endmodule

// File: tb/tb_tile_harness_mux.sv
// Directed bench for tile_harness_mux: 4 slots, 3-bit select so out-of-range slots can be requested.
module tb_tile_harness_mux;

  localparam int NT = 4;
  localparam int SW = 3;

  logic clk;
  logic arst_n;

  logic [NT-1:0]    t_rst_n;
  logic [NT*16-1:0] t_csr_in;
  logic [NT*32-1:0] t_data_reg_a;
  logic [NT*32-1:0] t_data_reg_b;
  logic [NT*8-1:0]  t_gpio_in;
  logic [NT-1:0]    t_csr_in_re;
  logic [NT*16-1:0] t_csr_out;
  logic [NT-1:0]    t_csr_out_we;
  logic [NT*32-1:0] t_data_reg_c;
  logic [NT*16-1:0] t_gpio_out;

  int num_checks = 0;
  int num_fails  = 0;
  int busy_cnt;
  int rst2_cnt;
  int ack_cnt;

  tile_harness_mux_if #(.SEL_W(SW)) hif_i ();

  tile_harness_mux #(.NUM_TILES(NT), .SEL_W(SW), .DRAIN_CYCLES(4)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .hif          (hif_i),
    .t_rst_n      (t_rst_n),
    .t_csr_in     (t_csr_in),
    .t_data_reg_a (t_data_reg_a),
    .t_data_reg_b (t_data_reg_b),
    .t_gpio_in    (t_gpio_in),
    .t_csr_in_re  (t_csr_in_re),
    .t_csr_out    (t_csr_out),
    .t_csr_out_we (t_csr_out_we),
    .t_data_reg_c (t_data_reg_c),
    .t_gpio_out   (t_gpio_out)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive every harness-side input in one go.
  task automatic applyStimulus(input logic hen, input logic ten, input logic req,
                               input logic [SW-1:0] sel, input logic [15:0] csr,
                               input logic [31:0] a, input logic [31:0] b);
    hif_i.harness_en = hen;
    hif_i.tile_en    = ten;
    hif_i.sel_req    = req;
    hif_i.tile_sel   = sel;
    hif_i.csr_in     = csr;
    hif_i.data_reg_a = a;
    hif_i.data_reg_b = b;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Main directed sequence.
  initial begin
    arst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    hif_i.gpios_in = '0;
    t_csr_in_re = '0; t_csr_out = '0; t_csr_out_we = '0; t_data_reg_c = '0; t_gpio_out = '0;

    // Reset state while arst_n is low.
    #2;
    checkOutput("rst_data_c", 128'(hif_i.data_reg_c), 128'h0);
    checkOutput("rst_active", 128'(hif_i.active_tile), 128'h0);
    checkOutput("rst_t_rst_n", 128'(t_rst_n), 128'h0);
    checkOutput("rst_busy_ack", 128'({hif_i.busy, hif_i.sel_ack, hif_i.sel_err}), 128'h0);
    checkOutput("rst_gpios_out", 128'(hif_i.gpios_out), 128'h0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    stepCycle();
    checkOutput("rel_t_rst_n", 128'(t_rst_n), 128'hF);

    // Tile 0 active: only slot 0 sees harness inputs, outputs come back registered.
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 16'h00A5, 32'h1234_5678, 32'h9ABC_DEF0);
    hif_i.gpios_in = {35{1'b1}};
    t_data_reg_c[31:0] = 32'hDEAD_BEEF;
    t_data_reg_c[95:64] = 32'h2222_2222;
    t_gpio_out = 64'h0000_0000_1111_BEEF;
    #1;
    checkOutput("t1_csr_in", 128'(t_csr_in), 128'h0000_0000_0000_00A5);
    checkOutput("t1_data_a", 128'(t_data_reg_a), 128'h1234_5678);
    checkOutput("t1_data_b", 128'(t_data_reg_b), 128'h9ABC_DEF0);
    checkOutput("t1_gpio_in", 128'(t_gpio_in), 128'h0000_00FF);
    stepCycle();
    checkOutput("t1_data_c", 128'(hif_i.data_reg_c), 128'hDEAD_BEEF);
    checkOutput("t1_gpios_out", 128'(hif_i.gpios_out), 128'h0_0000_BEEF);

    // csr_out captures on the write strobe and holds afterwards.
    t_csr_out[15:0] = 16'h1234; t_csr_out_we[0] = 1'b1;
    stepCycle();
    checkOutput("t5_csr_out_wr", 128'(hif_i.csr_out), 128'h1234);
    checkOutput("t5_csr_we_hi", 128'(hif_i.csr_out_we), 128'h1);
    t_csr_out[15:0] = 16'hFFFF; t_csr_out_we[0] = 1'b0; t_csr_in_re[0] = 1'b1;
    stepCycle();
    checkOutput("t5_csr_out_hold", 128'(hif_i.csr_out), 128'h1234);
    checkOutput("t5_csr_we_lo", 128'(hif_i.csr_out_we), 128'h0);
    checkOutput("t5_csr_in_re", 128'(hif_i.csr_in_re), 128'h1);
    t_csr_in_re[0] = 1'b0;

    // Out-of-range slot is rejected on the next cycle.
    hif_i.sel_req = 1'b1; hif_i.tile_sel = 3'd5;
    stepCycle();
    hif_i.sel_req = 1'b0;
    checkOutput("t3_ack_err", 128'({hif_i.sel_ack, hif_i.sel_err}), 128'h3);
    checkOutput("t3_active", 128'(hif_i.active_tile), 128'h0);
    checkOutput("t3_busy", 128'(hif_i.busy), 128'h0);
    stepCycle();
    checkOutput("t3_ack_drop", 128'(hif_i.sel_ack), 128'h0);

    // Selecting the already active slot acks without error.
    hif_i.sel_req = 1'b1; hif_i.tile_sel = 3'd0;
    stepCycle();
    hif_i.sel_req = 1'b0;
    checkOutput("same_ack_err", 128'({hif_i.sel_ack, hif_i.sel_err, hif_i.busy}), 128'h4);

    // Switch to slot 2; a second request during drain must be ignored.
    hif_i.sel_req = 1'b1; hif_i.tile_sel = 3'd2;
    busy_cnt = 0; rst2_cnt = 0; ack_cnt = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      stepCycle();
      if (hif_i.busy) busy_cnt++;
      if (!t_rst_n[2]) rst2_cnt++;
      if (hif_i.sel_ack) ack_cnt++;
      hif_i.sel_req = 1'b0;
      if (cyc == 1) begin
        checkOutput("t2_drain_mask", 128'(t_data_reg_a), 128'h0);
        t_data_reg_c[31:0] = 32'hCAFE_F00D;
      end
      if (cyc == 2) begin
        checkOutput("t2_drain_old", 128'(hif_i.data_reg_c), 128'hCAFE_F00D);
        hif_i.sel_req = 1'b1; hif_i.tile_sel = 3'd1;
      end
      if (cyc == 5) begin
        checkOutput("t2_switch_zero", 128'(hif_i.data_reg_c), 128'h0);
        checkOutput("t2_switch_rst", 128'(t_rst_n), 128'hB);
      end
      if (cyc == 6) begin
        checkOutput("t2_ack", 128'({hif_i.sel_ack, hif_i.sel_err}), 128'h2);
        checkOutput("t2_active", 128'(hif_i.active_tile), 128'h2);
      end
      if (cyc == 7) checkOutput("t2_new_data_c", 128'(hif_i.data_reg_c), 128'h2222_2222);
    end
    checkOutput("t2_busy_cycles", 128'(busy_cnt), 128'd5);
    checkOutput("t2_rst_cycles", 128'(rst2_cnt), 128'd1);
    checkOutput("t4_ack_count", 128'(ack_cnt), 128'd1);
    checkOutput("t2_csr_slot2", 128'(t_csr_in), 128'h0000_00A5_0000_0000);

    // Global enable low: every slot sees zeros, outputs still follow the tile.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 16'h00A5, 32'h1234_5678, 32'h9ABC_DEF0);
    t_data_reg_c[95:64] = 32'h3333_3333;
    t_gpio_out[47:32] = 16'hFFFF;
    #1;
    checkOutput("hen_csr_in", 128'(t_csr_in), 128'h0);
    checkOutput("hen_gpio_in", 128'(t_gpio_in), 128'h0);
    checkOutput("hen_data_b", 128'(t_data_reg_b), 128'h0);
    stepCycle();
    checkOutput("hen_data_c", 128'(hif_i.data_reg_c), 128'h3333_3333);
    checkOutput("hen_gpios_out", 128'(hif_i.gpios_out), 128'h0_0000_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'h00A5, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    checkOutput("ten_data_a", 128'(t_data_reg_a), 128'h0);

    // Reset in the second drain cycle discards the pending switch.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd1, 16'h00A5, 32'h1234_5678, 32'h9ABC_DEF0);
    stepCycle();
    hif_i.sel_req = 1'b0;
    stepCycle();
    checkOutput("t6_busy_pre", 128'(hif_i.busy), 128'h1);
    arst_n = 1'b0;
    #1;
    checkOutput("t6_busy", 128'(hif_i.busy), 128'h0);
    checkOutput("t6_active", 128'(hif_i.active_tile), 128'h0);
    checkOutput("t6_outputs",
                128'({hif_i.data_reg_c, hif_i.csr_out, hif_i.csr_out_we, hif_i.csr_in_re}), 128'h0);
    checkOutput("t6_t_rst_n", 128'(t_rst_n), 128'h0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    ack_cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      stepCycle();
      if (hif_i.sel_ack) ack_cnt++;
    end
    checkOutput("t6_no_ack", 128'(ack_cnt), 128'd0);
    checkOutput("t6_active_after", 128'(hif_i.active_tile), 128'h0);
    checkOutput("t6_t_rst_n_rel", 128'(t_rst_n), 128'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fails);
    $finish;
  end

endmodule
